// File: rtl/ascon_diffusion_inv_pkg.sv
// rtl/ascon_diffusion_inv_pkg.sv - shared types, rotation table and step helpers for the inverse diffusion layer
package ascon_diffusion_inv_pkg;

  // Five 64-bit words; word i of the state is x_i.
  typedef logic [4:0][63:0] type_state;

  // Number of squaring steps: L^63 = L * L^2 * L^4 * ... * L^32.
  localparam int DIFF_INV_STEPS = 6;

  // Rotation pairs (a_i, b_i) of the forward diffusion layer.
  // DIFF_ROT[i][0] = a_i, DIFF_ROT[i][1] = b_i.
  localparam logic [4:0][1:0][5:0] DIFF_ROT = {
    {6'd41, 6'd7},
    {6'd17, 6'd10},
    {6'd6,  6'd1},
    {6'd39, 6'd61},
    {6'd28, 6'd19}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } type_fsm;

  // Rotation amount of L^(2^k): the base amount times 2^k, modulo 64.
  function automatic logic [5:0] rot_amount(input logic [5:0] base, input logic [2:0] k);
    logic [5:0] r;
    r = base << k;
    return r;
  endfunction

endpackage

// File: rtl/ascon_diffusion_inv_step.sv
// rtl/ascon_diffusion_inv_step.sv - one word of one squaring step: x ^ rotr(x,a) ^ rotr(x,b)
module diffusion_inv_step (
  input  logic [63:0] word,
  input  logic [5:0]  amt_a,
  input  logic [5:0]  amt_b,
  output logic [63:0] result
);

  logic [127:0] dbl_a;
  logic [127:0] dbl_b;

  // Right rotation via a doubled word, so an amount of zero needs no special case.
  always_comb begin
    dbl_a  = {word, word} >> amt_a;
    dbl_b  = {word, word} >> amt_b;
    result = word ^ dbl_a[63:0] ^ dbl_b[63:0];
  end

endmodule

// File: rtl/ascon_diffusion_inv.sv
// rtl/ascon_diffusion_inv.sv - iterative inverse of the ASCON linear layer (optional ASCON_DIFF_INV_UNROLL2_EN: two steps per cycle)
module ascon_diffusion_inv
  import ascon_diffusion_inv_pkg::*;
(
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

`ifdef ASCON_DIFF_INV_UNROLL2_EN
  localparam logic [2:0] CNT_LAST = 3'(DIFF_INV_STEPS / 2 - 1);
`else
  localparam logic [2:0] CNT_LAST = 3'(DIFF_INV_STEPS - 1);
`endif

  type_fsm     fsm;
  logic [2:0]  cnt;
  type_state   acc;
  logic [63:0] acc_next [5];
  logic [2:0]  k0;
  logic [2:0]  k1;

  // Step exponents handled this cycle; the unrolled build covers steps 2*cnt and 2*cnt+1.
  always_comb begin
`ifdef ASCON_DIFF_INV_UNROLL2_EN
    k0 = cnt << 1;
    k1 = k0 | 3'd1;
`else
    k0 = cnt;
    k1 = cnt;
`endif
  end

  for (genvar i = 0; i < 5; i++) begin : g_word
`ifdef ASCON_DIFF_INV_UNROLL2_EN
    logic [63:0] mid;

    diffusion_inv_step u_step0 (
      .word   (acc[i]),
      .amt_a  (rot_amount(DIFF_ROT[i][0], k0)),
      .amt_b  (rot_amount(DIFF_ROT[i][1], k0)),
      .result (mid)
    );

    diffusion_inv_step u_step1 (
      .word   (mid),
      .amt_a  (rot_amount(DIFF_ROT[i][0], k1)),
      .amt_b  (rot_amount(DIFF_ROT[i][1], k1)),
      .result (acc_next[i])
    );
`else
    diffusion_inv_step u_step0 (
      .word   (acc[i]),
      .amt_a  (rot_amount(DIFF_ROT[i][0], k0)),
      .amt_b  (rot_amount(DIFF_ROT[i][1], k0)),
      .result (acc_next[i])
    );
`endif
  end

  // Control FSM, step counter and accumulator; outputs are registered.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm    <= ST_IDLE;
      cnt    <= 3'd0;
      acc    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (start_i) begin
            acc    <= state_i;
            cnt    <= 3'd0;
            busy_o <= 1'b1;
            fsm    <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < 5; i++) begin
            acc[i] <= acc_next[i];
          end
          cnt <= cnt + 3'd1;
          if (cnt == CNT_LAST) begin
            done_o <= 1'b1;
            fsm    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          fsm    <= ST_IDLE;
        end
        default: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          fsm    <= ST_IDLE;
        end
      endcase
    end
  end

  assign state_o = acc;

endmodule

// File: tb/tb_ascon_diffusion_inv.sv
// tb/tb_ascon_diffusion_inv.sv - randomized self-checking bench for ascon_diffusion_inv
module tb_ascon_diffusion_inv;
  import ascon_diffusion_inv_pkg::*;

`ifdef ASCON_DIFF_INV_UNROLL2_EN
  localparam int LAT   = 4;
  localparam int SPACE = 5;
`else
  localparam int LAT   = 7;
  localparam int SPACE = 8;
`endif

  logic      clock;
  logic      resetb;
  logic      start;
  type_state state_in;
  type_state state_out;
  logic      busy;
  logic      done;

  int n_checks = 0;
  int n_fail   = 0;

  ascon_diffusion_inv dut (
    .clock_i  (clock),
    .resetb_i (resetb),
    .start_i  (start),
    .state_i  (state_in),
    .state_o  (state_out),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: forward layer written straight from the rotation pairs.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state lin(input type_state s);
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};
    type_state r;
    for (int i = 0; i < 5; i++) r[i] = s[i] ^ rotr(s[i], ra[i]) ^ rotr(s[i], rb[i]);
    return r;
  endfunction

  // Inverse as 63 plain applications of the forward layer.
  function automatic type_state lin_inv(input type_state s);
    type_state r = s;
    for (int n = 0; n < 63; n++) r = lin(r);
    return r;
  endfunction

  function automatic type_state rand_state();
    type_state r;
    for (int i = 0; i < 5; i++) r[i] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_one(input string tag, input type_state s, input type_state exp);
    int lat;
    @(negedge clock);
    start = 1'b1;
    state_in = s;
    @(posedge clock);
    #1;
    start = 1'b0;
    state_in = rand_state();
    wait_done(lat);
    check({tag, "_lat"}, 320'(lat), 320'(LAT));
    check({tag, "_res"}, state_out, exp);
    check({tag, "_busy"}, 320'(busy), 320'(1));
    check({tag, "_fwd"}, lin(state_out), s);
  endtask

  initial begin
    type_state x, r1, r2, res1, res2;
    int lat, t1, t2, cyc, nd;

    resetb = 1'b0;
    start = 1'b0;
    state_in = '0;
    #12;
    check("rst_state", state_out, '0);
    check("rst_busy", 320'(busy), 320'(0));
    check("rst_done", 320'(done), 320'(0));
    @(negedge clock);
    resetb = 1'b1;

    run_one("zero", '0, '0);
    run_one("ones", {5{64'hFFFFFFFFFFFFFFFF}}, {5{64'hFFFFFFFFFFFFFFFF}});

    x[0] = 64'h78e2cc41faabaa1a;
    x[1] = 64'hbc7a2e775aababf7;
    x[2] = 64'h4b81c0cbbdb5fc1a;
    x[3] = 64'hb22e133e424f0250;
    x[4] = 64'h044d33702433805d;
    run_one("roundtrip", lin(x), x);

    for (int n = 0; n < 4; n++) begin
      r1 = rand_state();
      run_one($sformatf("rand%0d", n), r1, lin_inv(r1));
    end

    // Reset in the middle of a computation.
    @(negedge clock);
    start = 1'b1;
    state_in = rand_state();
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    resetb = 1'b0;
    #1;
    check("midrst_state", state_out, '0);
    check("midrst_busy", 320'(busy), 320'(0));
    check("midrst_done", 320'(done), 320'(0));
    @(negedge clock);
    resetb = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("midrst_nodone", 320'(nd), 320'(0));

    // Starts during RUN and DONE are ignored.
    r1 = rand_state();
    r2 = rand_state();
    @(negedge clock);
    start = 1'b1;
    state_in = r1;
    @(posedge clock);
    #1;
    start = 1'b0;
    state_in = r2;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = -1;
    for (int c = 4; c <= 30; c++) begin
      @(negedge clock);
      if (done) begin
        lat = c;
        break;
      end
    end
    check("ign_lat", 320'(lat), 320'(LAT));
    check("ign_res", state_out, lin_inv(r1));
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    check("ign_busy", 320'(busy), 320'(0));
    nd = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("ign_nodone", 320'(nd), 320'(0));
    check("ign_hold", state_out, lin_inv(r1));

    // start held high: back-to-back computations.
    r1 = rand_state();
    r2 = rand_state();
    @(negedge clock);
    start = 1'b1;
    state_in = r1;
    @(posedge clock);
    #1;
    state_in = r2;
    t1 = -1;
    t2 = -1;
    res1 = '0;
    res2 = '0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          res1 = state_out;
        end else begin
          t2 = cyc;
          res2 = state_out;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_lat1", 320'(t1), 320'(LAT));
    check("b2b_space", 320'(t2 - t1), 320'(SPACE));
    check("b2b_res1", res1, lin_inv(r1));
    check("b2b_res2", res2, lin_inv(r2));
    repeat (3) @(negedge clock);
    check("b2b_idle", 320'(busy), 320'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
